// File: rtl/data_mem_arbiter_pkg.sv
// Shared definitions for the data memory arbiter.
// Provides the default address and data widths, the address and data word
// types, the arbiter FSM state encoding and the latched operation type.
package data_mem_arbiter_pkg;

    localparam int unsigned DATA_MEMORY_ADDRESS_WIDTH = 8;
    localparam int unsigned DATA_WIDTH                = 32;

    typedef logic [DATA_MEMORY_ADDRESS_WIDTH-1:0] data_memory_address_t;
    typedef logic [DATA_WIDTH-1:0]                data_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_READ,
        RESPOND,
        COOLDOWN
    } arb_state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } mem_op_t;

endpackage

// File: rtl/data_mem_arbiter_rr_arbiter.sv
// Combinational round-robin selector.
// Ports:
//   req         - request vector, one bit per channel
//   ptr         - channel index with highest priority this round
//   grant       - one-hot grant (all zero when nothing requests)
//   grant_idx   - index of the granted channel
//   grant_valid - at least one request was present
module rr_arbiter #(
    parameter int unsigned N     = 8,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    int unsigned cand;

    // Scan starting at ptr and wrapping; the first requester found wins.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = 0;
        for (int unsigned off = 0; off < N; off++) begin
            cand = (32'(ptr) + off) % N;
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Data memory arbiter: serves NUM_CHANNELS read/write request channels, one
// transaction at a time, through a single backing-memory request port.
// Ports:
//   clk, reset (asynchronous, active-low)
//   ch_read_valid/ch_write_valid, ch_read_address/ch_write_address,
//   ch_write_data                   - per-channel held requests
//   ch_read_ready/ch_write_ready    - one-cycle completion pulses
//   ch_read_data                    - per-channel returned read word
//   mem_req_valid/mem_req_write/mem_addr/mem_wdata/mem_req_ready
//                                   - backing-memory request handshake
//   mem_rdata_valid/mem_rdata       - backing-memory read return
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS = 8,
    parameter int unsigned ADDR_W       = DATA_MEMORY_ADDRESS_WIDTH,
    parameter int unsigned DATA_W       = DATA_WIDTH
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_CHANNELS-1:0]             ch_read_valid,
    input  logic [NUM_CHANNELS-1:0]             ch_write_valid,
    input  logic [NUM_CHANNELS-1:0][ADDR_W-1:0] ch_read_address,
    input  logic [NUM_CHANNELS-1:0][ADDR_W-1:0] ch_write_address,
    input  logic [NUM_CHANNELS-1:0][DATA_W-1:0] ch_write_data,
    output logic [NUM_CHANNELS-1:0]             ch_read_ready,
    output logic [NUM_CHANNELS-1:0]             ch_write_ready,
    output logic [NUM_CHANNELS-1:0][DATA_W-1:0] ch_read_data,
    output logic                                mem_req_valid,
    output logic                                mem_req_write,
    output logic [ADDR_W-1:0]                   mem_addr,
    output logic [DATA_W-1:0]                   mem_wdata,
    input  logic                                mem_req_ready,
    input  logic                                mem_rdata_valid,
    input  logic [DATA_W-1:0]                   mem_rdata
);

    localparam int unsigned IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    arb_state_t              state;
    mem_op_t                 gnt_op;
    logic [IDX_W-1:0]        gnt_ch;
    logic [IDX_W-1:0]        rr_ptr;
    logic [NUM_CHANNELS-1:0] req_masked;
    logic [NUM_CHANNELS-1:0] arb_grant;
    logic [IDX_W-1:0]        arb_idx;
    logic                    arb_valid;
    logic                    arb_is_read;
    logic [IDX_W-1:0]        next_ptr;

    // The channel just served sits out the cooldown cycle so it cannot be
    // re-granted before its requester has seen the ready pulse.
    always_comb begin
        req_masked = ch_read_valid | ch_write_valid;
        if (state == COOLDOWN) begin
            req_masked[gnt_ch] = 1'b0;
        end
    end

    rr_arbiter #(
        .N     (NUM_CHANNELS),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req         (req_masked),
        .ptr         (rr_ptr),
        .grant       (arb_grant),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    // Read takes precedence when a channel holds both strobes.
    assign arb_is_read = |(arb_grant & ch_read_valid);
    assign next_ptr    = (arb_idx == IDX_W'(NUM_CHANNELS - 1)) ? '0 : arb_idx + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            gnt_op         <= OP_READ;
            gnt_ch         <= '0;
            rr_ptr         <= '0;
            mem_req_valid  <= 1'b0;
            mem_req_write  <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            ch_read_ready  <= '0;
            ch_write_ready <= '0;
            ch_read_data   <= '0;
        end else begin
            // Ready bits are set only on entry to RESPOND, so they clear
            // again on the following edge.
            ch_read_ready  <= '0;
            ch_write_ready <= '0;
            case (state)
                IDLE, COOLDOWN: begin
                    if (arb_valid) begin
                        gnt_ch        <= arb_idx;
                        gnt_op        <= arb_is_read ? OP_READ : OP_WRITE;
                        mem_req_valid <= 1'b1;
                        mem_req_write <= ~arb_is_read;
                        mem_addr      <= arb_is_read ? ch_read_address[arb_idx]
                                                     : ch_write_address[arb_idx];
                        mem_wdata     <= ch_write_data[arb_idx];
                        rr_ptr        <= next_ptr;
                        state         <= ISSUE;
                    end else begin
                        state <= IDLE;
                    end
                end
                ISSUE: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        if (gnt_op == OP_READ) begin
                            state <= WAIT_READ;
                        end else begin
                            ch_write_ready[gnt_ch] <= 1'b1;
                            state                  <= RESPOND;
                        end
                    end
                end
                WAIT_READ: begin
                    if (mem_rdata_valid) begin
                        ch_read_data[gnt_ch]  <= mem_rdata;
                        ch_read_ready[gnt_ch] <= 1'b1;
                        state                 <= RESPOND;
                    end
                end
                RESPOND: begin
                    state <= COOLDOWN;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
